// File: rtl/mem_bus_arbiter_pkg.sv
// Shared widths, FSM state encoding and bus-release values for the memory bus arbiter.
package mem_bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_TURN = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] IDLE_ADDR = '0;
  localparam logic [DATA_W-1:0] IDLE_DATA = '0;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshake plus memory-slave bus. The arbiter is the bus master toward memory;
// the slave modport is the environment view (requesters and memory model).
interface mem_bus_arbiter_if import mem_bus_pkg::*; #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_rd;
  logic                      mem_wr;
  logic [DATA_W-1:0]         mem_rdata;
  logic                      mem_ready;

  modport master (
    input  req, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    output gnt, done, rdata, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
    input  gnt, done, rdata, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request searching upward from i_last+1 (mod NUM_REQ).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);
  always_comb begin : pick
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(i_last) + k) % NUM_REQ;
      if (!o_any && i_req[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin memory bus arbiter: IDLE -> ADDR -> WAIT -> TURN per transfer, with a WAIT timeout.
module mem_bus_arbiter import mem_bus_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  state_e              r_state;
  state_e              w_next;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_idx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [TO_W-1:0]     r_cnt;
  logic                r_abort;
  logic [DATA_W-1:0]   r_rdata;

  logic [NUM_REQ-1:0]  w_win_oh;
  logic [IDX_W-1:0]    w_idx;
  logic                w_any;
  logic                w_tc;
  logic [NUM_REQ-1:0]  w_gnt;
  logic [NUM_REQ-1:0]  w_done;
  logic                w_err;
  logic [ADDR_W-1:0]   w_maddr;
  logic [DATA_W-1:0]   w_mwdata;
  logic                w_rd;
  logic                w_wr;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_gnt  (w_win_oh),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Last permitted WAIT cycle: the counter still holds the pre-increment count here.
  assign w_tc = (r_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_any) w_next = S_ADDR;
      S_ADDR: w_next = S_WAIT;
      S_WAIT: if (bus.mem_ready || w_tc) w_next = S_TURN;
      S_TURN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_any) begin
          r_idx   <= w_idx;
          r_last  <= w_idx;
          r_we    <= |(bus.req_we & w_win_oh);
          r_addr  <= bus.req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
          r_wdata <= bus.req_wdata[int'(w_idx)*DATA_W +: DATA_W];
          r_abort <= 1'b0;
        end
        S_WAIT: begin
          r_cnt <= r_cnt + TO_W'(1);
          // Ready wins over the terminal count, so a last-cycle ready is a clean success.
          if (bus.mem_ready) begin
            if (!r_we) r_rdata <= bus.mem_rdata;
          end else if (w_tc) begin
            r_abort <= 1'b1;
          end
        end
        S_TURN: begin
          r_cnt   <= '0;
          r_abort <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_gnt    = '0;
    w_done   = '0;
    w_err    = 1'b0;
    w_maddr  = IDLE_ADDR;
    w_mwdata = IDLE_DATA;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    unique case (r_state)
      S_ADDR: begin
        w_gnt[r_idx] = 1'b1;
        w_maddr      = r_addr;
        w_mwdata     = r_wdata;
      end
      S_WAIT: begin
        w_gnt[r_idx] = 1'b1;
        w_maddr      = r_addr;
        w_mwdata     = r_wdata;
        w_rd         = ~r_we;
        w_wr         = r_we;
      end
      S_TURN: begin
        w_gnt[r_idx]  = 1'b1;
        w_done[r_idx] = 1'b1;
        w_err         = r_abort;
      end
      default: ;
    endcase
  end

  assign bus.gnt       = w_gnt;
  assign bus.done      = w_done;
  assign bus.err       = w_err;
  assign bus.mem_addr  = w_maddr;
  assign bus.mem_wdata = w_mwdata;
  assign bus.mem_rd    = w_rd;
  assign bus.mem_wr    = w_wr;
  assign bus.rdata     = r_rdata;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Cycle-lockstep randomized bench for mem_bus_arbiter with a transaction-level round-robin model.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int N    = 4;
  localparam int TOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.NUM_REQ(N)) bus ();

  mem_bus_arbiter #(.NUM_REQ(N), .TIMEOUT(TOUT), .TO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] a  [N];
  logic [31:0] wd [N];
  logic        we [N];
  int          last_g;
  logic [31:0] exp_rdata;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++)
      if (m[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      a[i]  = 16'($urandom());
      wd[i] = $urandom();
      we[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic model_reset();
    last_g    = N - 1;
    exp_rdata = '0;
  endtask

  // Entered and left at an IDLE sample point (1 time unit after a posedge, DUT in IDLE).
  // wcyc: WAIT cycle index (0-based) on which ready is given; >= TOUT means never.
  task automatic run_xfer(input logic [N-1:0] mask, input int wcyc, input logic [31:0] rdv,
                          input bit do_rst, input bit drop);
    int         win;
    bit         rdy_seen;
    logic [N-1:0] eg;
    chk("idle_gnt", 64'(bus.gnt), 64'(0));
    chk("idle_done", 64'(bus.done), 64'(0));
    chk("idle_strb", 64'({bus.mem_rd, bus.mem_wr}), 64'(0));
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*16 +: 16]  = a[i];
      bus.req_wdata[i*32 +: 32] = wd[i];
      bus.req_we[i]             = we[i];
    end
    bus.req       = mask;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom();
    win = rr_pick(mask, last_g);
    @(posedge clk); #1;
    if (win < 0) begin
      bus.mem_ready = 1'b0;
      return;
    end
    last_g = win;
    eg = '0;
    eg[win] = 1'b1;
    chk("addr_gnt", 64'(bus.gnt), 64'(eg));
    chk("addr_maddr", 64'(bus.mem_addr), 64'(a[win]));
    chk("addr_strb", 64'({bus.mem_rd, bus.mem_wr}), 64'(0));
    chk("addr_rdata", 64'(bus.rdata), 64'(exp_rdata));
    if (drop) bus.req[win] = 1'b0;
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom();
    @(posedge clk); #1;
    rdy_seen = 1'b0;
    for (int k = 0; k < TOUT; k++) begin
      chk("wait_strb", 64'({bus.mem_rd, bus.mem_wr}), we[win] ? 64'(2'b01) : 64'(2'b10));
      chk("wait_maddr", 64'(bus.mem_addr), 64'(a[win]));
      chk("wait_wdata", 64'(bus.mem_wdata), 64'(wd[win]));
      chk("wait_gnt", 64'(bus.gnt), 64'(eg));
      chk("wait_done", 64'(bus.done), 64'(0));
      if (do_rst) begin
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_rd", 64'(bus.mem_rd), 64'(0));
        chk("rst_gnt", 64'(bus.gnt), 64'(0));
        chk("rst_maddr", 64'(bus.mem_addr), 64'(0));
        chk("rst_rdata", 64'(bus.rdata), 64'(0));
        bus.mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      bus.mem_ready = (k == wcyc);
      bus.mem_rdata = (k == wcyc) ? rdv : $urandom();
      @(posedge clk); #1;
      if (k == wcyc) begin
        rdy_seen = 1'b1;
        break;
      end
    end
    if (rdy_seen && !we[win]) exp_rdata = rdv;
    chk("turn_done", 64'(bus.done), 64'(eg));
    chk("turn_gnt", 64'(bus.gnt), 64'(eg));
    chk("turn_err", 64'(bus.err), 64'(!rdy_seen));
    chk("turn_maddr", 64'(bus.mem_addr), 64'(0));
    chk("turn_wdata", 64'(bus.mem_wdata), 64'(0));
    chk("turn_strb", 64'({bus.mem_rd, bus.mem_wr}), 64'(0));
    chk("turn_rdata", 64'(bus.rdata), 64'(exp_rdata));
    bus.mem_ready = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom();
    @(posedge clk); #1;
    chk("post_err", 64'(bus.err), 64'(0));
  endtask

  initial begin
    int r;
    int wc;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    model_reset();
    rand_fields();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_gnt", 64'(bus.gnt), 64'(0));
    chk("reset_done", 64'(bus.done), 64'(0));
    chk("reset_err", 64'(bus.err), 64'(0));
    chk("reset_strb", 64'({bus.mem_rd, bus.mem_wr}), 64'(0));
    chk("reset_maddr", 64'(bus.mem_addr), 64'(0));
    chk("reset_wdata", 64'(bus.mem_wdata), 64'(0));
    chk("reset_rdata", 64'(bus.rdata), 64'(0));
    rst = 1'b0;

    // fairness from reset: expect grant order 0,1,2,3,0 with zero-wait ready
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      run_xfer(4'b1111, 0, $urandom(), 1'b0, 1'b0);
      chk("fair_order", 64'(last_g), 64'(i % N));
    end

    // single read, ready on 2nd WAIT cycle
    rand_fields();
    a[0] = 16'h0040; we[0] = 1'b0;
    run_xfer(4'b0001, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
    chk("read_rdata", 64'(bus.rdata), 64'(32'hCAFE_F00D));

    // write leaves rdata unchanged
    rand_fields();
    a[2] = 16'h1234; wd[2] = 32'h0BAD_CAFE; we[2] = 1'b1;
    run_xfer(4'b0100, 2, 32'h1111_2222, 1'b0, 1'b0);
    chk("write_rdata", 64'(bus.rdata), 64'(32'hCAFE_F00D));

    // timeout, then a normal transfer; ready exactly on terminal count
    rand_fields();
    run_xfer(4'b0010, TOUT + 4, $urandom(), 1'b0, 1'b0);
    rand_fields();
    run_xfer(4'b0010, 0, $urandom(), 1'b0, 1'b0);
    rand_fields();
    run_xfer(4'b1000, TOUT - 1, $urandom(), 1'b0, 1'b0);

    // async reset mid-WAIT, then 1001 must grant requester 0
    rand_fields();
    run_xfer(4'b0110, 3, $urandom(), 1'b1, 1'b0);
    rand_fields();
    run_xfer(4'b1001, 0, $urandom(), 1'b0, 1'b0);
    chk("post_rst_first", 64'(last_g), 64'(0));

    // requester drops req mid-transfer; idle with no requests
    rand_fields();
    run_xfer(4'b0100, 1, $urandom(), 1'b0, 1'b1);
    run_xfer(4'b0000, 0, $urandom(), 1'b0, 1'b0);

    for (int t = 0; t < 200; t++) begin
      rand_fields();
      r  = $urandom_range(0, 9);
      wc = (r < 7) ? $urandom_range(0, 3) : ((r == 7) ? TOUT - 1 : TOUT + 5);
      run_xfer(N'($urandom_range(0, 15)), wc, $urandom(),
               ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory bus (16-bit address, 32-bit data) between NUM_REQ requesters using a request/grant handshake.
- Selects requesters round-robin and runs one read or write per grant.
- Inserts one idle turnaround cycle after every transfer, during which the bus is released.
- Sits between the task-level bus masters and the memory/slave interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum WAIT cycles before a transfer is aborted with an error (≥2).
- TO_W, 7, width of the timeout counter (≥ clog2(TIMEOUT+1)).

Ports:
- clk  in  1  system clock; all flops rise on posedge.
- rst  in  1  asynchronous reset, active-high.
- req  in  NUM_REQ  per-requester request; held until that requester's done.
- req_we  in  NUM_REQ  1 = write, 0 = read; sampled at grant.
- req_addr  in  NUM_REQ*16  flattened addresses; slice i = [16i+15:16i].
- req_wdata  in  NUM_REQ*32  flattened write data.
- gnt  out  NUM_REQ  one-hot grant; high from ADDR through TURN.
- done  out  NUM_REQ  one-cycle completion pulse, asserted in TURN.
- rdata  out  32  read data; valid while done is high; holds value otherwise.
- err  out  1  one-cycle pulse with done when the transfer timed out.
- mem_addr  out  16  bus address.
- mem_wdata  out  32  bus write data.
- mem_rd  out  1  read strobe.
- mem_wr  out  1  write strobe.
- mem_rdata  in  32  slave read data.
- mem_ready  in  1  slave completion; honoured only in WAIT.

Behaviour:
- Reset (async, immediate), all outputs zero:
  - FSM = IDLE; gnt, done, err, mem_rd, mem_wr = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - Timeout counter = 0.
- IDLE:
  - If any req is high, pick the first set bit searching upward (mod NUM_REQ) from last_grant+1.
  - Latch index, we, addr and wdata into internal registers.
  - Update last_grant; go to ADDR.
  - If no req is high, stay in IDLE.
- ADDR (1 cycle):
  - gnt[idx] = 1; mem_addr and mem_wdata driven from the latched values.
  - Strobes low (address setup). Go to WAIT.
- WAIT:
  - mem_rd = ~we, mem_wr = we; address and data held stable.
  - Counter increments each cycle.
  - mem_ready sampled high: capture mem_rdata into rdata (reads only; writes leave rdata unchanged); go to TURN.
  - Counter reaches TIMEOUT with mem_ready low: set an abort flag; go to TURN.
  - mem_ready high on the terminal-count cycle: treated as success; no err.
- TURN (1 cycle):
  - Strobes low; mem_addr and mem_wdata = 0 (bus released).
  - done[idx] = 1 and gnt[idx] = 1; err = abort flag.
  - Counter cleared. Next state IDLE.
- Latency: req sampled at edge N gives done at edge N+3 with zero-wait mem_ready. Each transfer occupies at least 4 cycles (IDLE, ADDR, WAIT, TURN).
- A requester dropping req mid-transfer is ignored; the transfer completes and done still pulses.
- A requester re-asserting req immediately after done is arbitrated normally; round-robin places it last.
- mem_ready in IDLE, ADDR or TURN is ignored and has no side effects.
- Invariants: gnt is one-hot or zero; mem_rd and mem_wr are never both high.

Decomposition:
- Package mem_bus_pkg holds:
  - ADDR_W = 16 and DATA_W = 32.
  - The state encoding IDLE/ADDR/WAIT/TURN as a 2-bit typedef.
  - The TURN idle address/data value 0.
- Sub-module rr_arbiter (NUM_REQ):
  - Combinational round-robin pick from req and last_grant.
  - Outputs a one-hot winner and its index, plus an any-request flag.
  - The top level holds the FSM, the latches and the counter.

Test Plan:
- Single read: req[0]=1, we=0, addr=16'h0040; mem_ready on the 2nd WAIT cycle with mem_rdata=32'hCAFE_F00D -> done[0] 4 cycles after the req edge, rdata=32'hCAFE_F00D, err=0, mem_rd high exactly 2 cycles.
- Fairness: req=4'b1111 held, zero-wait ready -> grant order 0,1,2,3,0; every done 4 cycles apart; mem_addr=0 in each TURN.
- Write: req[2]=1, we=1, addr=16'h1234, wdata=32'h0BAD_CAFE -> mem_wr=1 with stable addr/wdata until ready; rdata unchanged; done[2].
- Timeout: TIMEOUT=8, mem_ready never asserted -> mem_rd high 8 cycles, then done[i] and err together for one cycle; next request is served normally.
- Async reset mid-WAIT: assert rst between edges -> mem_rd, gnt and mem_addr go to 0 immediately; after release, req=4'b1001 grants requester 0 first.
- Stray ready: pulse mem_ready in IDLE and ADDR -> no done, no rdata change; transfer waits for a WAIT-state ready.
